// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: requests instructions from memory over a variable-latency
// req/ack handshake and owns the IF/ID pipeline register. It also drives the PC's hold
// control, so the PC advances exactly once per fetched instruction or on a redirect.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | just out of reset, no request yet
// WAIT    | request to pc_i outstanding
// HOLD    | fetched instruction buffered while the decode stage is stalled
// DISCARD | request cancelled by a flush is still outstanding; its data is dropped
module if_fetch_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0000)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_stall_o,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    input  logic              id_stall_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              valid_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] pc_plus4_q;
    logic              valid_q;
    logic [DATA_W-1:0] hold_instr_q;
    logic [ADDR_W-1:0] hold_pc4_q;
    logic [ADDR_W-1:0] discard_addr_q;

    logic [ADDR_W-1:0] pc_next;
    logic              fetch_done;

    // PC+4 wraps naturally at the top of the address space
    assign pc_next    = pc_i + ADDR_W'(4);
    assign fetch_done = (state_q == S_WAIT) & imem_ack_i;

    // Memory request and PC hold control; the PC is held throughout reset
    always_comb begin
        imem_req_o  = (state_q == S_WAIT) | (state_q == S_DISCARD);
        imem_addr_o = (state_q == S_DISCARD) ? discard_addr_q : pc_i;
        pc_stall_o  = ~rst_i | ~(flush_i | fetch_done);
    end

    // Fetch FSM, hold buffer and IF/ID register; priority is flush > stall > fetch
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q        <= S_IDLE;
            instr_q        <= NOP_INSTR;
            pc_plus4_q     <= '0;
            valid_q        <= 1'b0;
            hold_instr_q   <= '0;
            hold_pc4_q     <= '0;
            discard_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (flush_i) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        // an unanswered request must still be drained from memory
                        if (!imem_ack_i) begin
                            discard_addr_q <= pc_i;
                            state_q        <= S_DISCARD;
                        end
                    end else if (imem_ack_i) begin
                        if (id_stall_i) begin
                            hold_instr_q <= imem_rdata_i;
                            hold_pc4_q   <= pc_next;
                            state_q      <= S_HOLD;
                        end else begin
                            instr_q    <= imem_rdata_i;
                            pc_plus4_q <= pc_next;
                            valid_q    <= 1'b1;
                        end
                    end else if (!id_stall_i) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (flush_i) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        state_q <= S_WAIT;
                    end else if (!id_stall_i) begin
                        instr_q    <= hold_instr_q;
                        pc_plus4_q <= hold_pc4_q;
                        valid_q    <= 1'b1;
                        state_q    <= S_WAIT;
                    end
                end
                S_DISCARD: begin
                    // IF/ID stays a bubble until the cancelled response has arrived
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                    if (imem_ack_i) begin
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a directed vector table covering zero-wait
// fetch, two-cycle latency, stall/hold, flush/discard and address wrap, an
// asynchronous mid-request reset check, and a randomized run against a reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        pc_stall_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        id_stall_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pc_i        (pc_i),
        .pc_stall_o  (pc_stall_o),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_rdata_i(imem_rdata_i),
        .id_stall_i  (id_stall_i),
        .flush_i     (flush_i),
        .instr_o     (instr_o),
        .pc_plus4_o  (pc_plus4_o),
        .valid_o     (valid_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic        ack;
        logic        stall;
        logic        flush;
        logic        e_pstall;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t tbl[20];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, input int ack, input int stall,
                                input int flush, input int e_pstall, input int e_req,
                                input logic [31:0] e_addr, input int e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_pc4);
        vec_t v;
        v.pc       = pc;
        v.ack      = (ack != 0);
        v.stall    = (stall != 0);
        v.flush    = (flush != 0);
        v.e_pstall = (e_pstall != 0);
        v.e_req    = (e_req != 0);
        v.e_addr   = e_addr;
        v.e_valid  = (e_valid != 0);
        v.e_instr  = e_instr;
        v.e_pc4    = e_pc4;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: IF/ID contents, one-entry stall buffer, pending cancelled fetch, PC
    logic        m_started;
    logic        m_buf_v;
    logic [31:0] m_buf_instr;
    logic [31:0] m_buf_pc4;
    logic        m_doom_v;
    logic [31:0] m_doom_addr;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic [31:0] m_pc;

    task automatic model_reset();
        m_started   = 1'b0;
        m_buf_v     = 1'b0;
        m_buf_instr = '0;
        m_buf_pc4   = '0;
        m_doom_v    = 1'b0;
        m_doom_addr = '0;
        m_valid     = 1'b0;
        m_instr     = NOP;
        m_pc4       = '0;
        m_pc        = '0;
    endtask

    initial begin
        logic        exp_req;
        logic        exp_stall;
        logic [31:0] exp_addr;
        logic [31:0] tgt;
        logic        waiting;

        rst_i        = 1'b0;
        pc_i         = '0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;
        id_stall_i   = 1'b0;
        flush_i      = 1'b0;

        //          pc            ack st fl  pst req addr          vld instr                   pc4
        tbl[0]  = mk(32'h0,        0, 0, 0,  1, 0, 32'h0,         0, NOP,                    32'h0);
        tbl[1]  = mk(32'h0,        1, 0, 0,  0, 1, 32'h0,         0, NOP,                    32'h0);
        tbl[2]  = mk(32'h4,        1, 0, 0,  0, 1, 32'h4,         1, mem_word(32'h0),        32'h4);
        tbl[3]  = mk(32'h8,        1, 0, 0,  0, 1, 32'h8,         1, mem_word(32'h4),        32'h8);
        tbl[4]  = mk(32'hC,        0, 0, 0,  1, 1, 32'hC,         1, mem_word(32'h8),        32'hC);
        tbl[5]  = mk(32'hC,        1, 0, 0,  0, 1, 32'hC,         0, NOP,                    32'h0);
        tbl[6]  = mk(32'h10,       1, 1, 0,  0, 1, 32'h10,        1, mem_word(32'hC),        32'h10);
        tbl[7]  = mk(32'h14,       0, 1, 0,  1, 0, 32'h14,        1, mem_word(32'hC),        32'h10);
        tbl[8]  = mk(32'h14,       1, 1, 0,  1, 0, 32'h14,        1, mem_word(32'hC),        32'h10);
        tbl[9]  = mk(32'h14,       0, 0, 0,  1, 0, 32'h14,        1, mem_word(32'hC),        32'h10);
        tbl[10] = mk(32'h14,       0, 0, 0,  1, 1, 32'h14,        1, mem_word(32'h10),       32'h14);
        tbl[11] = mk(32'h14,       1, 0, 0,  0, 1, 32'h14,        0, NOP,                    32'h0);
        tbl[12] = mk(32'h20,       0, 0, 1,  0, 1, 32'h20,        1, mem_word(32'h14),       32'h18);
        tbl[13] = mk(32'h80,       0, 0, 0,  1, 1, 32'h20,        0, NOP,                    32'h0);
        tbl[14] = mk(32'h80,       0, 0, 0,  1, 1, 32'h20,        0, NOP,                    32'h0);
        tbl[15] = mk(32'h80,       1, 0, 0,  1, 1, 32'h20,        0, NOP,                    32'h0);
        tbl[16] = mk(32'h80,       1, 0, 0,  0, 1, 32'h80,        0, NOP,                    32'h0);
        tbl[17] = mk(32'hFFFF_FFFC,1, 0, 0,  0, 1, 32'hFFFF_FFFC, 1, mem_word(32'h80),       32'h84);
        tbl[18] = mk(32'h0,        0, 0, 0,  1, 1, 32'h0,         1, mem_word(32'hFFFF_FFFC),32'h0);
        tbl[19] = mk(32'h4,        1, 0, 0,  0, 1, 32'h4,         0, NOP,                    32'h0);

        // values while reset is held
        @(negedge clk_i);
        #1;
        chk("rst_req",    {31'b0, imem_req_o}, 32'd0);
        chk("rst_pstall", {31'b0, pc_stall_o}, 32'd1);
        chk("rst_valid",  {31'b0, valid_o},    32'd0);
        chk("rst_instr",  instr_o,             NOP);
        chk("rst_pc4",    pc_plus4_o,          32'h0);

        // directed table, first row applied in the cycle reset is released
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            pc_i         = tbl[i].pc;
            imem_ack_i   = tbl[i].ack;
            id_stall_i   = tbl[i].stall;
            flush_i      = tbl[i].flush;
            imem_rdata_i = mem_word(tbl[i].e_addr);
            #1;
            chk($sformatf("tbl%0d_pstall", i), {31'b0, pc_stall_o}, {31'b0, tbl[i].e_pstall});
            chk($sformatf("tbl%0d_req", i),    {31'b0, imem_req_o}, {31'b0, tbl[i].e_req});
            if (tbl[i].e_req)
                chk($sformatf("tbl%0d_addr", i), imem_addr_o, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i),  {31'b0, valid_o},    {31'b0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_instr", i),  instr_o,             tbl[i].e_instr);
            if (tbl[i].e_valid)
                chk($sformatf("tbl%0d_pc4", i), pc_plus4_o, tbl[i].e_pc4);
            @(negedge clk_i);
        end

        // asynchronous reset in the middle of a WAIT cycle, before the next rising edge
        pc_i       = 32'h8;
        imem_ack_i = 1'b0;
        #1;
        chk("pre_rst_valid", {31'b0, valid_o}, 32'd1);
        chk("pre_rst_pc4",   pc_plus4_o,       32'h8);
        chk("pre_rst_req",   {31'b0, imem_req_o}, 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        chk("async_rst_valid",  {31'b0, valid_o},    32'd0);
        chk("async_rst_instr",  instr_o,             NOP);
        chk("async_rst_pc4",    pc_plus4_o,          32'h0);
        chk("async_rst_req",    {31'b0, imem_req_o}, 32'd0);
        chk("async_rst_pstall", {31'b0, pc_stall_o}, 32'd1);

        // randomized run against the reference model
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            flush_i    = ($urandom_range(0, 9) == 0);
            id_stall_i = ($urandom_range(0, 9) < 3);
            imem_ack_i = ($urandom_range(0, 1) == 1);
            tgt        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & ~32'h3);
            pc_i       = m_pc;
            waiting    = m_started && !m_buf_v && !m_doom_v;
            exp_req    = m_started && !m_buf_v;
            exp_addr   = m_doom_v ? m_doom_addr : m_pc;
            exp_stall  = !(flush_i || (waiting && imem_ack_i));
            imem_rdata_i = exp_req ? mem_word(exp_addr) : $urandom;
            #1;
            chk("rnd_pstall", {31'b0, pc_stall_o}, {31'b0, exp_stall});
            chk("rnd_req",    {31'b0, imem_req_o}, {31'b0, exp_req});
            if (exp_req)
                chk("rnd_addr", imem_addr_o, exp_addr);
            chk("rnd_valid",  {31'b0, valid_o},    {31'b0, m_valid});
            chk("rnd_instr",  instr_o,             m_instr);
            if (m_valid)
                chk("rnd_pc4", pc_plus4_o, m_pc4);

            // advance the model to what the coming rising edge should produce
            if (!m_started) begin
                m_started = 1'b1;
            end else if (m_doom_v) begin
                m_valid = 1'b0;
                m_instr = NOP;
                if (imem_ack_i) m_doom_v = 1'b0;
            end else if (m_buf_v) begin
                if (flush_i) begin
                    m_buf_v = 1'b0;
                    m_valid = 1'b0;
                    m_instr = NOP;
                end else if (!id_stall_i) begin
                    m_buf_v = 1'b0;
                    m_valid = 1'b1;
                    m_instr = m_buf_instr;
                    m_pc4   = m_buf_pc4;
                end
            end else if (imem_ack_i) begin
                if (flush_i) begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                end else if (id_stall_i) begin
                    m_buf_v     = 1'b1;
                    m_buf_instr = mem_word(m_pc);
                    m_buf_pc4   = m_pc + 32'd4;
                end else begin
                    m_valid = 1'b1;
                    m_instr = mem_word(m_pc);
                    m_pc4   = m_pc + 32'd4;
                end
            end else if (flush_i) begin
                m_doom_v    = 1'b1;
                m_doom_addr = m_pc;
                m_valid     = 1'b0;
                m_instr     = NOP;
            end else if (!id_stall_i) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end

            if (!exp_stall)
                m_pc = flush_i ? tgt : m_pc + 32'd4;

            @(negedge clk_i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
